// File: rtl/mc_pkg.sv
// Shared types and widths for the memory-controller bank path.
// Request layouts, FSM states and small helpers.
package mc_pkg;

   localparam logic READ  = 1'b1;
   localparam logic WRITE = 1'b0;

   localparam int RA_BITS    = 16;
   localparam int DATA_BITS  = 16;
   localparam int INDEX_BITS = 7;
   localparam int ARR_NUM_RD = 4;
   localparam int ARR_NUM_WR = 3;

   typedef struct packed {
      logic [INDEX_BITS-1:0] index;
      logic [RA_BITS-1:0]    row;
   } rd_req_t;

   typedef struct packed {
      logic [INDEX_BITS-1:0] index;
      logic [DATA_BITS-1:0]  data;
      logic [RA_BITS-1:0]    row;
   } wr_req_t;

   typedef enum logic [1:0] {
      ST_RD    = 2'd0,
      ST_RD2WR = 2'd1,
      ST_WR    = 2'd2,
      ST_WR2RD = 2'd3
   } sched_state_e;

   function automatic int count_wr(input logic [ARR_NUM_WR-1:0] v);
      int c;
      c = 0;
      for (int i = 0; i < ARR_NUM_WR; i++) begin
         if (v[i]) c++;
      end
      return c;
   endfunction

endpackage

// File: rtl/rr_hit_picker.sv
// Round-robin picker with open-row hit priority.
// Returns a one-hot grant, its encoded index and an any-valid flag.
module rr_hit_picker #(
   parameter int N  = 4,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  i_valid,
   input  logic [N-1:0]  i_hit,
   input  logic [PW-1:0] i_ptr,
   input  logic          i_force_miss,
   output logic [N-1:0]  o_grant,
   output logic [PW-1:0] o_idx,
   output logic          o_any
);

   logic [N-1:0] w_hit_vld;
   logic         w_use_hit;
   logic [N-1:0] w_elig;
   logic         w_found;
   int           w_j;

   assign w_hit_vld = i_valid & i_hit;
   assign w_use_hit = (|w_hit_vld) && !i_force_miss;
   assign w_elig    = w_use_hit ? w_hit_vld : i_valid;
   assign o_any     = |i_valid;

   // walk the slots starting at the pointer, first eligible one wins
   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      w_found = 1'b0;
      w_j     = 0;
      for (int k = 0; k < N; k++) begin
         w_j = int'(i_ptr) + k;
         if (w_j >= N) w_j = w_j - N;
         if (!w_found && w_elig[w_j]) begin
            w_found     = 1'b1;
            o_grant[w_j] = 1'b1;
            o_idx       = PW'(w_j);
         end
      end
   end

endmodule

// File: rtl/bank_issue_scheduler.sv
// Per-bank issue stage: picks one read or write head per cycle
// and holds it in a registered valid/ready output stage.
module bank_issue_scheduler
   import mc_pkg::*;
#(
   parameter int WR_HIGH      = 2,
   parameter int MAX_WR_BURST = 4,
   parameter int MAX_HITS     = 4
) (
   input  logic                                             clk,
   input  logic                                             rst_n,
   input  logic [ARR_NUM_RD-1:0]                            rd_valid,
   input  logic [ARR_NUM_RD*(RA_BITS+INDEX_BITS)-1:0]       rd_data,
   input  logic [ARR_NUM_WR-1:0]                            wr_valid,
   input  logic [ARR_NUM_WR*(RA_BITS+DATA_BITS+INDEX_BITS)-1:0] wr_data,
   output logic [ARR_NUM_RD-1:0]                            rd_pop,
   output logic [ARR_NUM_WR-1:0]                            wr_pop,
   output logic                                             req_valid,
   input  logic                                             req_ready,
   output logic                                             req_type,
   output logic [RA_BITS-1:0]                               req_row,
   output logic [DATA_BITS-1:0]                             req_data,
   output logic [INDEX_BITS-1:0]                            req_index
);

   localparam int RD_W = RA_BITS + INDEX_BITS;
   localparam int WR_W = RA_BITS + DATA_BITS + INDEX_BITS;
   localparam int RPW  = $clog2(ARR_NUM_RD);
   localparam int WPW  = $clog2(ARR_NUM_WR);
   localparam int BW   = $clog2(MAX_WR_BURST + 1);
   localparam int HW   = $clog2(MAX_HITS + 1);

   sched_state_e          r_state;
   sched_state_e          w_state_nxt;
   logic [BW-1:0]         r_wr_burst;
   logic [BW-1:0]         w_burst_nxt;
   logic [HW-1:0]         r_hit_cnt;
   logic [HW-1:0]         w_hit_nxt;
   logic [RA_BITS-1:0]    r_open_row;
   logic                  r_open_vld;
   logic [RPW-1:0]        r_rd_ptr;
   logic [WPW-1:0]        r_wr_ptr;

   logic                  r_valid;
   logic                  r_type;
   logic [RA_BITS-1:0]    r_row;
   logic [DATA_BITS-1:0]  r_data;
   logic [INDEX_BITS-1:0] r_index;

   rd_req_t               w_rd_head [ARR_NUM_RD];
   wr_req_t               w_wr_head [ARR_NUM_WR];
   logic [ARR_NUM_RD-1:0] w_rd_hit;
   logic [ARR_NUM_WR-1:0] w_wr_hit;
   logic [ARR_NUM_RD-1:0] w_rd_gnt;
   logic [ARR_NUM_WR-1:0] w_wr_gnt;
   logic [RPW-1:0]        w_rd_idx;
   logic [WPW-1:0]        w_wr_idx;
   logic                  w_rd_any;
   logic                  w_wr_any;
   rd_req_t               w_rd_sel;
   wr_req_t               w_wr_sel;

   logic                  w_force;
   logic                  w_can_out;
   logic                  w_rd_issue;
   logic                  w_wr_issue;
   logic                  w_issue;
   logic                  w_sel_hit;
   logic                  w_miss_avail;
   logic [RA_BITS-1:0]    w_sel_row;
   logic                  w_any_vld;
   int                    w_wr_cnt;

   for (genvar gi = 0; gi < ARR_NUM_RD; gi++) begin : g_rd
      assign w_rd_head[gi] = rd_data[gi*RD_W +: RD_W];
      assign w_rd_hit[gi]  = r_open_vld &&
                             (w_rd_head[gi].row == r_open_row);
   end

   for (genvar gi = 0; gi < ARR_NUM_WR; gi++) begin : g_wr
      assign w_wr_head[gi] = wr_data[gi*WR_W +: WR_W];
      assign w_wr_hit[gi]  = r_open_vld &&
                             (w_wr_head[gi].row == r_open_row);
   end

   // after MAX_HITS hits past a waiting miss, the next pick is plain rr
   assign w_force = (r_hit_cnt >= HW'(MAX_HITS));

   rr_hit_picker #(.N(ARR_NUM_RD)) u_rd_pick (
      .i_valid      (rd_valid),
      .i_hit        (w_rd_hit),
      .i_ptr        (r_rd_ptr),
      .i_force_miss (w_force),
      .o_grant      (w_rd_gnt),
      .o_idx        (w_rd_idx),
      .o_any        (w_rd_any)
   );

   rr_hit_picker #(.N(ARR_NUM_WR)) u_wr_pick (
      .i_valid      (wr_valid),
      .i_hit        (w_wr_hit),
      .i_ptr        (r_wr_ptr),
      .i_force_miss (w_force),
      .o_grant      (w_wr_gnt),
      .o_idx        (w_wr_idx),
      .o_any        (w_wr_any)
   );

   assign w_rd_sel   = w_rd_head[w_rd_idx];
   assign w_wr_sel   = w_wr_head[w_wr_idx];
   assign w_can_out  = !r_valid || req_ready;
   // rst_n gate keeps pops low while reset is held
   assign w_rd_issue = rst_n && (r_state == ST_RD) &&
                       w_rd_any && w_can_out;
   assign w_wr_issue = rst_n && (r_state == ST_WR) &&
                       w_wr_any && w_can_out;
   assign w_issue    = w_rd_issue || w_wr_issue;
   assign w_sel_hit  = w_wr_issue ? w_wr_hit[w_wr_idx] :
                                    w_rd_hit[w_rd_idx];
   assign w_sel_row  = w_wr_issue ? w_wr_sel.row : w_rd_sel.row;
   assign w_miss_avail = w_wr_issue ? |(wr_valid & ~w_wr_hit) :
                                      |(rd_valid & ~w_rd_hit);
   assign w_any_vld  = (|rd_valid) || (|wr_valid);
   assign w_wr_cnt   = count_wr(wr_valid);

   assign w_burst_nxt = (w_wr_issue && r_wr_burst != BW'(MAX_WR_BURST)) ?
                        r_wr_burst + 1'b1 : r_wr_burst;

   assign w_hit_nxt = (w_force || !w_sel_hit || !w_miss_avail) ?
                      '0 : r_hit_cnt + 1'b1;

   // mode selection and combinational fifo pops
   always_comb begin
      w_state_nxt = r_state;
      rd_pop      = '0;
      wr_pop      = '0;
      if (w_rd_issue) rd_pop = w_rd_gnt;
      if (w_wr_issue) wr_pop = w_wr_gnt;
      unique case (r_state)
         ST_RD: begin
            if (w_any_vld &&
                (w_wr_cnt >= WR_HIGH || !(|rd_valid)))
               w_state_nxt = ST_RD2WR;
         end
         ST_RD2WR: w_state_nxt = ST_WR;
         ST_WR: begin
            if (w_any_vld &&
                (!(|wr_valid) ||
                 (w_burst_nxt == BW'(MAX_WR_BURST) && (|rd_valid))))
               w_state_nxt = ST_WR2RD;
         end
         ST_WR2RD: w_state_nxt = ST_RD;
         default:  w_state_nxt = ST_RD;
      endcase
   end

   // mode state and write-burst counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_RD;
         r_wr_burst <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == ST_RD2WR)
            r_wr_burst <= '0;
         else
            r_wr_burst <= w_burst_nxt;
      end
   end

   // output stage, open row, hit streak and rr pointers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid    <= 1'b0;
         r_type     <= 1'b0;
         r_row      <= '0;
         r_data     <= '0;
         r_index    <= '0;
         r_open_row <= '0;
         r_open_vld <= 1'b0;
         r_hit_cnt  <= '0;
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
      end else begin
         if (w_rd_issue) begin
            r_valid  <= 1'b1;
            r_type   <= READ;
            r_row    <= w_rd_sel.row;
            r_data   <= '0;
            r_index  <= w_rd_sel.index;
            r_rd_ptr <= (w_rd_idx == RPW'(ARR_NUM_RD - 1)) ?
                        '0 : w_rd_idx + 1'b1;
         end else if (w_wr_issue) begin
            r_valid  <= 1'b1;
            r_type   <= WRITE;
            r_row    <= w_wr_sel.row;
            r_data   <= w_wr_sel.data;
            r_index  <= w_wr_sel.index;
            r_wr_ptr <= (w_wr_idx == WPW'(ARR_NUM_WR - 1)) ?
                        '0 : w_wr_idx + 1'b1;
         end else if (req_ready) begin
            r_valid <= 1'b0;
         end
         if (w_issue) begin
            r_open_row <= w_sel_row;
            r_open_vld <= 1'b1;
            r_hit_cnt  <= w_hit_nxt;
         end
      end
   end

   assign req_valid = r_valid;
   assign req_type  = r_type;
   assign req_row   = r_row;
   assign req_data  = r_data;
   assign req_index = r_index;

endmodule

// File: tb/tb_bank_issue_scheduler.sv
// Bench for bank_issue_scheduler: vector table, directed corner
// sequences and random traffic against a queue-based model.
module tb_bank_issue_scheduler;
   import mc_pkg::*;

   localparam int RDW = RA_BITS + INDEX_BITS;
   localparam int WRW = RA_BITS + DATA_BITS + INDEX_BITS;
   localparam int MAXH = 4;
   localparam int MAXB = 4;
   localparam int WRH  = 2;

   logic clk = 1'b0;
   logic rst_n;
   logic [ARR_NUM_RD-1:0] rd_valid;
   logic [ARR_NUM_RD*RDW-1:0] rd_data;
   logic [ARR_NUM_WR-1:0] wr_valid;
   logic [ARR_NUM_WR*WRW-1:0] wr_data;
   logic [ARR_NUM_RD-1:0] rd_pop;
   logic [ARR_NUM_WR-1:0] wr_pop;
   logic req_valid, req_ready, req_type;
   logic [RA_BITS-1:0] req_row;
   logic [DATA_BITS-1:0] req_data;
   logic [INDEX_BITS-1:0] req_index;

   bank_issue_scheduler #(
      .WR_HIGH(WRH), .MAX_WR_BURST(MAXB), .MAX_HITS(MAXH)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .rd_valid(rd_valid), .rd_data(rd_data),
      .wr_valid(wr_valid), .wr_data(wr_data),
      .rd_pop(rd_pop), .wr_pop(wr_pop),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_type(req_type), .req_row(req_row),
      .req_data(req_data), .req_index(req_index)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   rd_req_t rq [ARR_NUM_RD][$];
   wr_req_t wq [ARR_NUM_WR][$];
   int acc_q[$];
   string pat;

   // model state: mode flag + pending turnaround flag
   bit m_wm, m_turn, m_open_vld, m_ov, m_ot;
   int m_hits, m_burst;
   int m_ptr [2];
   logic [15:0] m_open_row, m_orow, m_odata;
   logic [6:0] m_oidx;
   bit p_iss;
   int p_j;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", nm, act, exp);
   endtask

   task automatic chk_s(string nm, string act, string exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %s want %s", nm, act, exp);
   endtask

   function automatic int acc_at(int k);
      return (k < acc_q.size()) ? acc_q[k] : -1;
   endfunction

   task automatic drive_heads();
      for (int i = 0; i < ARR_NUM_RD; i++) begin
         rd_valid[i] = rq[i].size() > 0;
         rd_data[i*RDW +: RDW] = (rq[i].size() > 0) ? rq[i][0] : '0;
      end
      for (int i = 0; i < ARR_NUM_WR; i++) begin
         wr_valid[i] = wq[i].size() > 0;
         wr_data[i*WRW +: WRW] = (wq[i].size() > 0) ? wq[i][0] : '0;
      end
   endtask

   function automatic int ncls(bit wm);
      return wm ? ARR_NUM_WR : ARR_NUM_RD;
   endfunction

   function automatic bit hv(bit wm, int j);
      return wm ? (wq[j].size() > 0) : (rq[j].size() > 0);
   endfunction

   function automatic logic [15:0] hrow(bit wm, int j);
      return wm ? wq[j][0].row : rq[j][0].row;
   endfunction

   function automatic bit is_hit(bit wm, int j);
      return m_open_vld && hrow(wm, j) == m_open_row;
   endfunction

   function automatic int nvalid(bit wm);
      int c = 0;
      for (int j = 0; j < ncls(wm); j++) if (hv(wm, j)) c++;
      return c;
   endfunction

   task automatic model_reset();
      m_wm = 0; m_turn = 0; m_open_vld = 0; m_ov = 0; m_ot = 0;
      m_hits = 0; m_burst = 0; m_ptr[0] = 0; m_ptr[1] = 0;
      m_open_row = 0; m_orow = 0; m_odata = 0; m_oidx = 0;
   endtask

   task automatic model_pick();
      int first = -1;
      int fh = -1;
      int n = ncls(m_wm);
      for (int k = 0; k < n; k++) begin
         int j = (m_ptr[m_wm] + k) % n;
         if (hv(m_wm, j)) begin
            if (first < 0) first = j;
            if (fh < 0 && is_hit(m_wm, j)) fh = j;
         end
      end
      p_j = (m_hits < MAXH && fh >= 0) ? fh : first;
      p_iss = !m_turn && first >= 0 && (!m_ov || req_ready);
   endtask

   task automatic model_update();
      int rc = nvalid(0);
      int wc = nvalid(1);
      int n = ncls(m_wm);
      if (p_iss) begin
         bit h = is_hit(m_wm, p_j);
         bit miss = 0;
         for (int j = 0; j < n; j++)
            if (hv(m_wm, j) && !is_hit(m_wm, j)) miss = 1;
         if (m_hits >= MAXH || !h || !miss) m_hits = 0;
         else m_hits++;
         m_ov = 1;
         m_ot = !m_wm;
         if (m_wm) begin
            m_orow = wq[p_j][0].row;
            m_odata = wq[p_j][0].data;
            m_oidx = wq[p_j][0].index;
            void'(wq[p_j].pop_front());
            m_burst++;
         end else begin
            m_orow = rq[p_j][0].row;
            m_odata = 0;
            m_oidx = rq[p_j][0].index;
            void'(rq[p_j].pop_front());
         end
         m_open_row = m_orow;
         m_open_vld = 1;
         m_ptr[m_wm] = (p_j + 1) % n;
      end else if (req_ready) begin
         m_ov = 0;
      end
      if (m_turn) begin
         m_turn = 0;
         m_wm = !m_wm;
         if (m_wm) m_burst = 0;
      end else if (rc + wc == 0) begin
         m_turn = 0;
      end else if (!m_wm) begin
         if (wc >= WRH || rc == 0) m_turn = 1;
      end else if (wc == 0 || (m_burst >= MAXB && rc > 0)) begin
         m_turn = 1;
      end
   endtask

   // one clock: check pops against the model, advance, check outputs
   task automatic step();
      logic [3:0] erp;
      logic [2:0] ewp;
      drive_heads();
      #1;
      model_pick();
      erp = '0;
      ewp = '0;
      if (p_iss && m_wm) ewp[p_j] = 1'b1;
      if (p_iss && !m_wm) erp[p_j] = 1'b1;
      chk("pop", {rd_pop, wr_pop}, {erp, ewp});
      if (req_valid && req_ready) acc_q.push_back(int'(req_index));
      pat = {pat, (|rd_pop) ? "R" : (|wr_pop) ? "W" : "-"};
      @(posedge clk);
      model_update();
      #1;
      chk("out", {req_valid, req_type, req_row, req_data, req_index},
          {m_ov, m_ot, m_orow, m_odata, m_oidx});
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      for (int i = 0; i < ARR_NUM_RD; i++) rq[i].delete();
      for (int i = 0; i < ARR_NUM_WR; i++) wq[i].delete();
      model_reset();
      drive_heads();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   function automatic rd_req_t mk_rd(int idx, int row);
      rd_req_t r;
      r.index = INDEX_BITS'(idx);
      r.row = RA_BITS'(row);
      return r;
   endfunction

   function automatic wr_req_t mk_wr(int idx, int row, int d);
      wr_req_t w;
      w.index = INDEX_BITS'(idx);
      w.row = RA_BITS'(row);
      w.data = DATA_BITS'(d);
      return w;
   endfunction

   typedef struct {
      bit wr;
      int fifo;
      logic [6:0] idx;
      logic [15:0] row;
      logic [15:0] data;
      logic [3:0] erp;
      logic [2:0] ewp;
      int lat;
   } vec_t;

   initial begin
      vec_t vt [5];
      int nidx;

      vt[0] = '{0, 2, 7'h05, 16'h1234, 16'h0000, 4'b0100, 3'b000, 0};
      vt[1] = '{0, 0, 7'h11, 16'hBEEF, 16'h0000, 4'b0001, 3'b000, 0};
      vt[2] = '{0, 3, 7'h7F, 16'hFFFF, 16'h0000, 4'b1000, 3'b000, 0};
      vt[3] = '{1, 1, 7'h22, 16'h0042, 16'hCAFE, 4'b0000, 3'b010, 2};
      vt[4] = '{1, 2, 7'h00, 16'h0000, 16'hFFFF, 4'b0000, 3'b100, 2};

      rst_n = 1'b0;
      req_ready = 1'b0;
      rd_valid = '0;
      rd_data = '0;
      wr_valid = '0;
      wr_data = '0;
      model_reset();
      @(negedge clk);
      #1;
      chk("reset_hold", {req_valid, req_type, req_row, req_data,
                         req_index, rd_pop, wr_pop}, '0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle", {req_valid, req_type, req_row, req_data,
                   req_index, rd_pop, wr_pop}, '0);

      // single request from reset, per table
      for (int v = 0; v < 5; v++) begin
         do_reset();
         req_ready = 1'b1;
         if (vt[v].wr)
            wq[vt[v].fifo].push_back(
               mk_wr(int'(vt[v].idx), int'(vt[v].row), int'(vt[v].data)));
         else
            rq[vt[v].fifo].push_back(
               mk_rd(int'(vt[v].idx), int'(vt[v].row)));
         for (int c = 0; c <= vt[v].lat; c++) begin
            drive_heads();
            #1;
            chk("vec_pop", {rd_pop, wr_pop},
                (c == vt[v].lat) ? {vt[v].erp, vt[v].ewp} : 7'd0);
            @(posedge clk);
            #1;
            if (c == vt[v].lat) begin
               if (vt[v].wr) void'(wq[vt[v].fifo].pop_front());
               else void'(rq[vt[v].fifo].pop_front());
               chk("vec_out",
                   {req_valid, req_type, req_row, req_data, req_index},
                   {1'b1, !vt[v].wr, vt[v].row,
                    vt[v].wr ? vt[v].data : 16'h0, vt[v].idx});
            end
            @(negedge clk);
         end
      end

      // row hit beats rr pointer
      do_reset();
      req_ready = 1'b1;
      rq[3].push_back(mk_rd(1, 'h1234));
      step(); step();
      rq[0].push_back(mk_rd(2, 'h0001));
      rq[3].push_back(mk_rd(3, 'h1234));
      acc_q.delete();
      repeat (4) step();
      chk("hit_first", acc_at(0), 3);
      chk("hit_second", acc_at(1), 2);

      // hit streak capped so the waiting miss gets through
      do_reset();
      req_ready = 1'b1;
      rq[3].push_back(mk_rd(9, 'hAAAA));
      step(); step();
      for (int i = 0; i < 6; i++) rq[1].push_back(mk_rd(10 + i, 'hAAAA));
      rq[0].push_back(mk_rd(20, 'hBBBB));
      acc_q.delete();
      repeat (9) step();
      begin
         int exp_o [7] = '{10, 11, 12, 13, 20, 14, 15};
         for (int i = 0; i < 7; i++) chk("starve_order", acc_at(i), exp_o[i]);
      end

      // write drain with bubbles on both turnarounds
      do_reset();
      req_ready = 1'b1;
      for (int i = 0; i < 8; i++) rq[0].push_back(mk_rd(40 + i, 'h100 + i));
      step(); step();
      for (int i = 0; i < 3; i++) begin
         wq[0].push_back(mk_wr(60 + i, 'h200 + i, 'h1000 + i));
         wq[1].push_back(mk_wr(70 + i, 'h300 + i, 'h2000 + i));
      end
      pat = "";
      repeat (8) step();
      chk_s("drain_pattern", pat, "R-WWWW-R");

      // backpressure: hold then drain in order
      do_reset();
      req_ready = 1'b0;
      for (int i = 0; i < 6; i++) rq[0].push_back(mk_rd(30 + i, 'h300 + i));
      step();
      repeat (5) begin
         step();
         chk("bp_hold", {req_valid, req_type, req_row, req_index,
                         rd_pop, wr_pop},
             {1'b1, 1'b1, 16'h0300, 7'd30, 4'b0, 3'b0});
      end
      req_ready = 1'b1;
      acc_q.delete();
      repeat (8) step();
      chk("bp_count", acc_q.size(), 6);
      for (int i = 0; i < 6; i++) chk("bp_order", acc_at(i), 30 + i);

      // reset while a request is held
      req_ready = 1'b0;
      for (int i = 0; i < 3; i++) rq[2].push_back(mk_rd(50 + i, 'h500));
      step(); step();
      chk("pre_rst_valid", req_valid, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("rst_out", {req_valid, rd_pop, wr_pop}, '0);
      chk("rst_open", dut.r_open_vld, 1'b0);
      chk("rst_state", dut.r_state, ST_RD);
      @(negedge clk);
      do_reset();

      // random traffic against the model
      nidx = 0;
      for (int cyc = 0; cyc < 800; cyc++) begin
         for (int i = 0; i < ARR_NUM_RD; i++)
            if (rq[i].size() < 4 && $urandom_range(0, 4) == 0) begin
               rq[i].push_back(mk_rd(nidx, 'h10 + $urandom_range(0, 2)));
               nidx = (nidx + 1) % 128;
            end
         for (int i = 0; i < ARR_NUM_WR; i++)
            if (wq[i].size() < 4 && $urandom_range(0, 5) == 0) begin
               wq[i].push_back(mk_wr(nidx, 'h10 + $urandom_range(0, 2),
                                     int'($urandom_range(0, 65535))));
               nidx = (nidx + 1) % 128;
            end
         req_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      req_ready = 1'b1;
      repeat (60) step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
